// File: rtl/keypad_pkg.sv
// Shared types, row/column constants and the key map for the 4x4 hex keypad scanner.
// The auto-repeat timing constants are used only when KEYPAD_AUTOREPEAT_EN is defined.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_kind_t;

  localparam logic [3:0] ROW_0    = 4'b1110;
  localparam logic [3:0] ROW_1    = 4'b1101;
  localparam logic [3:0] ROW_2    = 4'b1011;
  localparam logic [3:0] ROW_3    = 4'b0111;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  localparam int REPEAT_DELAY_FRAMES = 64;
  localparam int REPEAT_RATE_FRAMES  = 16;

  // row_idx 0 is row 1110, col_idx 0 is column bit 0
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h7;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h1;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h8;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h2;
      4'b01_11: code = 4'hA;
      4'b10_00: code = 4'h9;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h3;
      4'b10_11: code = 4'hB;
      4'b11_00: code = 4'hC;
      4'b11_01: code = 4'hD;
      4'b11_10: code = 4'hE;
      default:  code = 4'hF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_frame_decode.sv
// Accumulates the four per-row column samples of one scan frame and classifies the
// frame as NONE, SINGLE(code) or MULTI at the closing (row 0111) sample.
module keypad_frame_decode
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [1:0]  row_idx,
  input  logic [3:0]  col,
  output logic        frame_done,
  output frame_kind_t frame_kind,
  output logic [3:0]  code
);

  logic [1:0] acc_zeros;
  logic [3:0] acc_code;
  logic [2:0] cur_zeros;
  logic [1:0] cur_col;
  logic [2:0] tot_zeros;
  logic [1:0] merged_zeros;
  logic [3:0] merged_code;

  // zero count saturates at 2: anything beyond one pressed contact is MULTI
  always_comb begin
    cur_zeros = '0;
    cur_col   = '0;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        cur_zeros = cur_zeros + 3'd1;
        cur_col   = 2'(c);
      end
    end
    tot_zeros    = {1'b0, acc_zeros} + cur_zeros;
    merged_zeros = (tot_zeros >= 3'd2) ? 2'd2 : tot_zeros[1:0];
    merged_code  = (cur_zeros == 3'd1) ? key_map(row_idx, cur_col) : acc_code;
    frame_done   = sample_en && (row_idx == 2'd3);
    code         = merged_code;
    case (merged_zeros)
      2'd0:    frame_kind = FR_NONE;
      2'd1:    frame_kind = FR_SINGLE;
      default: frame_kind = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_zeros <= '0;
      acc_code  <= '0;
    end else if (frame_done) begin
      acc_zeros <= '0;
      acc_code  <= '0;
    end else if (sample_en) begin
      acc_zeros <= merged_zeros;
      acc_code  <= merged_code;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Paced row scanner, per-frame debounce FSM and single-entry valid/ready event register
// for the 4x4 keypad. Define KEYPAD_AUTOREPEAT_EN to re-emit a held key periodically.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_SCANS);

  logic [DIV_W-1:0] divider;
  logic [1:0]       row_idx;
  logic             sample_en;
  logic             frame_done;
  frame_kind_t      frame_kind;
  logic [3:0]       frame_code;

  kp_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       cand, cand_n;
  logic             single_cand;
  logic             accept;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY_FRAMES + 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= DB_MAX) ? DB_MAX : c + CNT_W'(1);
  endfunction

  assign sample_en = (divider == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divider <= '0;
      row_idx <= '0;
    end else if (sample_en) begin
      divider <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      divider <= divider + DIV_W'(1);
    end
  end

  always_comb begin
    case (row_idx)
      2'd0:    keypadRow = ROW_0;
      2'd1:    keypadRow = ROW_1;
      2'd2:    keypadRow = ROW_2;
      default: keypadRow = ROW_3;
    endcase
  end

  keypad_frame_decode u_decode (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .row_idx    (row_idx),
    .col        (keypadCol),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .code       (frame_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cand_n      = cand;
    accept      = 1'b0;
    single_cand = (frame_kind == FR_SINGLE) && (frame_code == cand);
    key_held    = (state == HELD) || (state == RELEASE_DB);
    if (frame_done) begin
      unique case (state)
        IDLE: begin
          if (frame_kind == FR_SINGLE) begin
            cand_n = frame_code;
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (single_cand) begin
            cnt_n = sat_inc(cnt);
            if (sat_inc(cnt) >= DB_MAX) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          if (!single_cand) begin
            cnt_n   = CNT_W'(1);
            state_n = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (single_cand) begin
            state_n = HELD;
          end else begin
            cnt_n = sat_inc(cnt);
            if (sat_inc(cnt) >= DB_MAX) state_n = IDLE;
          end
        end
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    // repeat count restarts only on a fresh press; a release bounce leaves it alone
    rep_cnt_n = rep_cnt;
    if (frame_done && (state == IDLE || state == PRESS_DB) && state_n == HELD) begin
      rep_cnt_n = '0;
    end else if (frame_done && state == HELD && single_cand) begin
      if (rep_cnt >= REP_W'(REPEAT_DELAY_FRAMES - 1)) begin
        accept    = 1'b1;
        rep_cnt_n = REP_W'(REPEAT_DELAY_FRAMES - REPEAT_RATE_FRAMES);
      end else begin
        rep_cnt_n = rep_cnt + REP_W'(1);
      end
    end
`endif
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_cnt <= '0;
    else        rep_cnt <= rep_cnt_n;
  end
`endif

  // a full register drops the new press unless it is being handed off this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      if (!key_valid || key_ready) begin
        key_code  <= cand_n;
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a frame-level key model predicts events,
// a monitor compares every handshake against the expected queue.
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keypadCol;
  logic [3:0] keypadRow;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .reset     (reset),
    .keypadCol (keypadCol),
    .keypadRow (keypadRow),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  typedef struct {
    int         frame;
    logic [3:0] code;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  int          frame_no = 0;
  logic [15:0] pressed = '0;
  ev_t         exp_q[$];
  logic [3:0]  keymap [4][4];

  bit m_held, m_slot_full, m_overrun, ready_hold;
  int m_held_key, m_run_key, m_run_len, m_off_len;

  // physical keypad: a pressed key shorts its column to the active row
  always_comb begin
    keypadCol = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (keypadRow[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[keymap[r][c]]) keypadCol[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_held = 0; m_slot_full = 0; m_overrun = 0;
    m_held_key = 0; m_run_key = 0; m_run_len = 0; m_off_len = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int k);
    ev_t e;
    if (m_slot_full) begin
      m_overrun = 1;
    end else begin
      e.frame = frame_no;
      e.code  = 4'(k);
      exp_q.push_back(e);
      if (!ready_hold) m_slot_full = 1;
    end
  endtask

  task automatic model_frame();
    int n;
    int k;
    bit single;
    n = $countones(pressed);
    k = 0;
    for (int i = 0; i < 16; i++) if (pressed[i]) k = i;
    single = (n == 1);
    if (m_held) begin
      if (single && k == m_held_key) begin
        m_off_len = 0;
      end else begin
        m_off_len++;
        if (m_off_len >= DS) begin
          m_held = 0;
          m_run_len = 0;
        end
      end
    end else if (single) begin
      if (m_run_len > 0 && k != m_run_key) begin
        m_run_len = 0;
      end else begin
        m_run_key = k;
        m_run_len++;
        if (m_run_len >= DS) begin
          model_accept(k);
          m_held = 1; m_held_key = k; m_off_len = 0; m_run_len = 0;
        end
      end
    end else begin
      m_run_len = 0;
    end
  endtask

  task automatic run_frame(input logic [15:0] p);
    pressed = p;
    repeat (FRAME / 2) tick();
    check("held_mid", key_held, m_held);
    repeat (FRAME / 2) tick();
    frame_no++;
    model_frame();
  endtask

  initial begin : monitor
    bit prev;
    int rise;
    ev_t e;
    prev = 0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 0;
      end else begin
        if (key_valid && !prev) rise = frame_no;
        if (key_valid && key_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got code %0h, expected no event", key_code);
          end else begin
            e = exp_q.pop_front();
            check("event_code", key_code, e.code);
            check("event_frame", rise, e.frame);
          end
        end
        prev = key_valid;
      end
    end
  end

  initial begin : stim
    logic [15:0] p;
    int sel, len, a, b, n;
    logic [3:0] rows [4];
    keymap = '{'{4'h7, 4'h4, 4'h1, 4'h0}, '{4'h8, 4'h5, 4'h2, 4'hA},
               '{4'h9, 4'h6, 4'h3, 4'hB}, '{4'hC, 4'hD, 4'hE, 4'hF}};
    rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    key_ready = 1'b1;
    ready_hold = 1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_row", keypadRow, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_code", key_code, 4'h0);
    reset = 1'b1;

    // first frame: row strobe sequence and pacing
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      if (i % SCAN_DIV == 0) check("row_seq", keypadRow, rows[i / SCAN_DIV - 1]);
    end
    frame_no++;
    model_frame();

    repeat (3) run_frame(16'(1) << 5);
    repeat (3) run_frame('0);
    repeat (2) run_frame(16'(1) << 9);
    run_frame('0);
    repeat (3) run_frame(16'(1) << 9);
    repeat (3) run_frame('0);
    repeat (6) run_frame((16'(1) << 1) | (16'(1) << 2));
    repeat (2) run_frame('0);

    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 5);
      if (sel < 35) begin
        p = '0;
      end else if (sel < 85) begin
        p = 16'(1) << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        p = (16'(1) << a) | (16'(1) << b);
      end
      repeat (len) run_frame(p);
    end
    repeat (4) run_frame('0);
    check("overrun_clear", overrun, m_overrun);

    // blocked consumer: second press is dropped
    key_ready = 1'b0;
    ready_hold = 0;
    repeat (3) run_frame(16'(1) << 10);
    repeat (3) run_frame('0);
    repeat (3) run_frame(16'(1) << 3);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_pending", exp_q.size(), 1);
    if (exp_q.size() > 0) check("ovr_code", key_code, exp_q[0].code);
    check("ovr_flag", overrun, m_overrun);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    m_slot_full = 0;
    check("valid_drop", key_valid, 1'b0);
    repeat (FRAME - 1) tick();
    frame_no++;
    model_frame();
    key_ready = 1'b1;
    ready_hold = 1;
    repeat (4) run_frame('0);
    check("ovr_sticky", overrun, m_overrun);

    // asynchronous reset while an event is pending
    key_ready = 1'b0;
    ready_hold = 0;
    repeat (3) run_frame(16'(1) << 5);
    repeat (5) tick();
    check("pre_rst_valid", key_valid, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("arst_row", keypadRow, 4'b1110);
    check("arst_valid", key_valid, 1'b0);
    check("arst_held", key_held, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    model_reset();
    pressed = '0;
    key_ready = 1'b1;
    ready_hold = 1;
    tick();
    reset = 1'b1;
    n = 0;
    while (keypadRow == 4'b1110 && n < 12) begin
      tick();
      n++;
    end
    check("first_row_step", n, SCAN_DIV);
    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
